adc_uart_tx: RTL

ADC_UART_TX -- requirements
Module: adc_uart_tx

---
 rtl/adc_uart_tx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/adc_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : adc_uart_tx
// Purpose  : Drains 16-bit FIFO samples to a UART as 3-byte 8N1 packets
//            (sync byte, sample high byte, sample low byte).
// Revision : 1.0 - initial release
// ============================================================================
module adc_uart_tx #(
   parameter int         CLKS_PER_BIT = 87,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic        uart_clk,
   input  logic        i_rest_n,
   input  logic        tx_en,
   input  logic        rdempty,
   input  logic [15:0] o_fifo,
   output logic        rdreq,
   output logic        uart_tx,
   output logic        tx_busy,
   output logic [15:0] word_cnt
);

   localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_START   = 3'd3,
      S_DATA    = 3'd4,
      S_STOP    = 3'd5
   } state_t;

   state_t              r_state;
   logic [c_baud_w-1:0] r_baud;
   logic [2:0]          r_bit;
   logic [1:0]          r_byte;
   logic [15:0]         r_hold;
   logic                r_armed;

   logic [7:0]          w_cur_byte;
   logic                w_baud_done;

   always_comb begin
      w_cur_byte = SYNC_BYTE;
      case (r_byte)
         2'd1:    w_cur_byte = r_hold[15:8];
         2'd2:    w_cur_byte = r_hold[7:0];
         default: w_cur_byte = SYNC_BYTE;
      endcase
   end

   assign w_baud_done = (r_baud == c_baud_last);

   // r_armed holds off the first read for one cycle after reset release
   always_ff @(posedge uart_clk) begin
      if (!i_rest_n) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_byte   <= '0;
         r_hold   <= '0;
         r_armed  <= 1'b0;
         uart_tx  <= 1'b1;
         rdreq    <= 1'b0;
         tx_busy  <= 1'b0;
         word_cnt <= '0;
      end else begin
         r_armed <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_baud <= '0;
               if (r_armed && tx_en && !rdempty) begin
                  r_state <= S_RD_REQ;
                  rdreq   <= 1'b1;
                  tx_busy <= 1'b1;
               end
            end
            S_RD_REQ: begin
               rdreq   <= 1'b0;
               r_state <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               r_hold  <= o_fifo;
               r_byte  <= '0;
               r_baud  <= '0;
               uart_tx <= 1'b0;
               r_state <= S_START;
            end
            S_START: begin
               if (w_baud_done) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  uart_tx <= w_cur_byte[0];
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + c_baud_w'(1);
               end
            end
            S_DATA: begin
               if (w_baud_done) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     uart_tx <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     uart_tx <= w_cur_byte[r_bit + 3'd1];
                  end
               end else begin
                  r_baud <= r_baud + c_baud_w'(1);
               end
            end
            S_STOP: begin
               if (w_baud_done) begin
                  r_baud <= '0;
                  if (r_byte != 2'd2) begin
                     r_byte  <= r_byte + 2'd1;
                     uart_tx <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     word_cnt <= word_cnt + 16'd1;
                     tx_busy  <= 1'b0;
                     r_state  <= S_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + c_baud_w'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_baud  <= '0;
               uart_tx <= 1'b1;
               rdreq   <= 1'b0;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
